// File: rtl/alu_ctrl_pkg.sv
// Shared ALU op codes and arbiter FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_XOR   = 2'b01;
  localparam logic [1:0] ALU_PASSB = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bus between two requesters, the consumer and the ALU arbiter.
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [3:0]         req_op;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [WIDTH-1:0]   resp_result;
  logic               resp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_zero
  );
endinterface

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU: add, xor, pass-B, sub (all modulo 2^WIDTH) with zero flag.
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_PASSB: result_o = b_i;
      ALU_SUB:   result_o = a_i - b_i;
      default:   result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; IDLE -> EXEC -> RESP per op.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_rr_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_rr_arbiter_if.slave       bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
`endif
);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             resp_id_q, resp_id_d;

  logic             gnt_vld, gnt_id, accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Contest goes to the requester that did not win last time.
  assign gnt_vld = |bus.req_valid;
  assign gnt_id  = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
  assign accept  = (state_q == S_IDLE) && gnt_vld && !rst;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      resp_id_q    <= resp_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          a_d          = gnt_id ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
          b_d          = gnt_id ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
          op_d         = gnt_id ? bus.req_op[3:2] : bus.req_op[1:0];
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d  = alu_result;
        zero_d    = alu_zero;
        resp_id_d = id_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = 2'b00;
    bus.resp_valid  = (state_q == S_RESP);
    bus.resp_id     = resp_id_q;
    bus.resp_result = result_q;
    bus.resp_zero   = zero_q;
    if (accept) bus.req_ready = gnt_id ? 2'b10 : 2'b01;
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (!gnt_id && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (gnt_id && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed cases then randomized traffic against a behavioural model.
module tb_alu_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   exp_last = 1;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;

  alu_rr_arbiter_if #(.WIDTH(16)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0, gc1;
`endif

  alu_rr_arbiter #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = (a + b) % 65536;
      1: r = a ^ b;
      2: r = b;
      default: r = (a - b + 65536) % 65536;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt();
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", {16'h0, gc0}, exp_cnt0);
    chk("grant_cnt1", {16'h0, gc1}, exp_cnt1);
`endif
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
  task automatic txn(input logic [1:0] vld,
                     input logic [15:0] a0, input logic [15:0] b0, input logic [1:0] op0,
                     input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] op1,
                     input int stall, input bit keep);
    int id;
    logic [15:0] er;
    bus.req_valid  = vld;
    bus.req_a      = {a1, a0};
    bus.req_b      = {b1, b0};
    bus.req_op     = {op1, op0};
    bus.resp_ready = (stall == 0);
    #1;
    if (vld == 2'b11) id = (exp_last == 1) ? 0 : 1;
    else              id = vld[1] ? 1 : 0;
    chk("req_ready_grant", {30'h0, bus.req_ready}, (id == 0) ? 1 : 2);
    exp_last = id;
    if (id == 0) begin if (exp_cnt0 < 65535) exp_cnt0++; end
    else         begin if (exp_cnt1 < 65535) exp_cnt1++; end
    er = (id == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 2'b00;
    #1;
    chk("exec_resp_valid", {31'h0, bus.resp_valid}, 0);
    chk("exec_req_ready", {30'h0, bus.req_ready}, 0);
    @(posedge clk); #1;
    chk("resp_valid", {31'h0, bus.resp_valid}, 1);
    chk("resp_id", {31'h0, bus.resp_id}, id);
    chk("resp_result", {16'h0, bus.resp_result}, er);
    chk("resp_zero", {31'h0, bus.resp_zero}, (er == 16'h0));
    chk("resp_req_ready", {30'h0, bus.req_ready}, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, bus.resp_valid}, 1);
      chk("hold_result", {16'h0, bus.resp_result}, er);
      chk("hold_req_ready", {30'h0, bus.req_ready}, 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", {31'h0, bus.resp_valid}, 0);
    chk_cnt();
  endtask

  initial begin
    logic [1:0] v;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 0);
    chk("rst_req_ready", {30'h0, bus.req_ready}, 0);
    chk("rst_resp_id", {31'h0, bus.resp_id}, 0);
    chk("rst_resp_result", {16'h0, bus.resp_result}, 0);
    chk("rst_resp_zero", {31'h0, bus.resp_zero}, 0);
    chk_cnt();
    @(posedge clk); #1;

    // Single requests, zero flag, contention, wrap, backpressure
    txn(2'b01, 16'h0001, 16'h0001, 2'b00, 16'h0, 16'h0, 2'b00, 0, 0);
    txn(2'b10, 16'h0, 16'h0, 2'b00, 16'h0008, 16'h0008, 2'b11, 0, 0);
    for (int k = 0; k < 4; k++)
      txn(2'b11, 16'h0005, 16'h0003, 2'b01, 16'h0, 16'h0010, 2'b10, 0, 1);
    bus.req_valid = 2'b00;
    txn(2'b01, 16'h0000, 16'h0001, 2'b11, 16'h0, 16'h0, 2'b00, 0, 0);
    txn(2'b01, 16'hFFFF, 16'h0001, 2'b00, 16'h0, 16'h0, 2'b00, 0, 0);
    txn(2'b10, 16'h0, 16'h0, 2'b00, 16'h1234, 16'h4321, 2'b00, 5, 0);

    // Accept requester 0, then reset while in EXEC
    bus.req_valid = 2'b01;
    bus.req_a = {16'h0, 16'h0007};
    bus.req_b = {16'h0, 16'h0007};
    bus.req_op = 4'b0000;
    #1;
    chk("pre_rst_grant", {30'h0, bus.req_ready}, 1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last = 1; exp_cnt0 = 0; exp_cnt1 = 0;
    #1;
    chk("exec_rst_resp_valid", {31'h0, bus.resp_valid}, 0);
    chk("exec_rst_result", {16'h0, bus.resp_result}, 0);
    chk("exec_rst_zero", {31'h0, bus.resp_zero}, 0);
    chk("exec_rst_id", {31'h0, bus.resp_id}, 0);
    chk("exec_rst_req_ready", {30'h0, bus.req_ready}, 0);
    chk_cnt();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("exec_rst_no_resp", {31'h0, bus.resp_valid}, 0);
    end
    txn(2'b11, 16'h0003, 16'h0004, 2'b00, 16'h0009, 16'h0002, 2'b11, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.req_valid = 2'b00;
        #1;
        chk("idle_req_ready", {30'h0, bus.req_ready}, 0);
        @(posedge clk); #1;
        chk("idle_resp_valid", {31'h0, bus.resp_valid}, 0);
      end else begin
        v = 2'($urandom_range(1, 3));
        txn(v, 16'($urandom), 16'($urandom), 2'($urandom),
            16'($urandom), 16'($urandom), 2'($urandom),
            $urandom_range(0, 3), 1'($urandom));
      end
    end
    bus.req_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one `alu` instance (WIDTH-bit; ops 00 add, 01 xor, 10 pass-B, 11 sub; zero flag) between two requesters using round-robin arbitration.
- Each request carries operands and an op. Requests and responses use a valid/ready handshake.
- Each result is returned with the requester id and held until the consumer accepts it.
- Sits between the decode/issue logic and the shared ALU datapath.

Parameters:
- WIDTH, 16, operand/result width; passed through to the `alu` instance.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; request accepted when req_valid[i] && req_ready[i]
- req_a  in  2*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  2*WIDTH  operand B, same packing
- req_op  in  4  alu op; requester i at [2*i +: 2]
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester id of the result
- resp_result  out  WIDTH  ALU result
- resp_zero  out  1  ALU zero flag for that result

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset -> IDLE.
- Reset values:
  - req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_zero=0
  - operand/op/id registers = 0
  - last_grant=1, so requester 0 wins the first contest.
- IDLE:
  - req_ready is combinational and one-hot at most: the bit of the granted requester only.
  - Only req_valid feeds req_ready; req_ready never depends on resp_ready.
  - Grant rule:
    - one valid -> grant it;
    - both valid -> grant the requester != last_grant;
    - none valid -> stay in IDLE, req_ready=0.
  - On grant: latch a/b/op/id, update last_grant, go to EXEC.
- EXEC (1 cycle):
  - ALU is driven from the latched registers.
  - Capture result into resp_result and zero flag into resp_zero; resp_id = latched id.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_* stable while resp_valid && !resp_ready.
  - On resp_ready -> IDLE. A new grant is possible in the following cycle.
  - req_ready=0 throughout EXEC and RESP.
- Timing:
  - Latency: accept at cycle N -> resp_valid at N+2.
  - Minimum initiation interval: 3 cycles per op.
- Arithmetic: modulo 2^WIDTH; add/sub wrap silently, no carry/overflow output.
- A requester that deasserts req_valid before being granted is simply not served.
- No starvation: with both requesters continuously valid, grants alternate 0,1,0,1.
- Reset asserted in EXEC or RESP:
  - the in-flight op is discarded and no response is produced;
  - all outputs return to reset values next cycle;
  - last_grant returns to 1.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - Each counts accepted requests for its requester and saturates at 16'hFFFF.
  - Both reset to 0 on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg holds:
  - op constants ALU_ADD=2'b00, ALU_XOR=2'b01, ALU_PASSB=2'b10, ALU_SUB=2'b11;
  - FSM state encoding S_IDLE/S_EXEC/S_RESP.
- Sub-module: the existing `alu` is instantiated once. Round-robin pick logic stays inline; it is too small to warrant its own module.

Test Plan:
- Reset, then single request: req_valid=01, a=0x0001, b=0x0001, op=00, resp_ready=1 -> req_ready=01 that cycle; two cycles later resp_valid=1, id=0, result=0x0002, zero=0.
- Zero flag: requester 1, a=0x0008, b=0x0008, op=11 -> result=0x0000, zero=1, id=1.
- Contention: both valid continuously, req0 op=01 (0x0005^0x0003), req1 op=10 (b=0x0010) -> response order id 0 (0x0006), 1 (0x0010), 0, 1; never two consecutive grants to the same id.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid with a=0x1234, b=0x4321, add -> resp_result holds 0x5555, req_ready stays 00; resp_ready=1 -> IDLE next cycle.
- Wrap: a=0x0000, b=0x0001, sub -> 0xFFFF, zero=0; a=0xFFFF, b=0x0001, add -> 0x0000, zero=1.
- Reset in EXEC: assert rst the cycle after accept -> resp_valid never rises; outputs at reset values; next contest won by requester 0. With ALU_ARB_STATS_EN, counters read 0 after reset.
